e2_out_decoder: RTL and testbench

Companion monitor for the e2 controller. It samples the controller's 18-bit Mealy output word and decodes each non-idle pattern into a 5-bit transition code. Each code is queued in a small show-ahead event FIFO with a valid/ready read port, and a saturating per-code occurrence counter is kept for each code. It sits beside the controller in the test/observation wrapper and detects illegal output patterns and unexpected repetition counts.

---
 rtl/e2_out_decoder.sv | 119 +++++++++++
 tb/tb_e2_out_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/e2_out_decoder.sv
// Observation monitor for the e2 controller: decodes the 18-bit output word into
// transition codes, queues them in a show-ahead FIFO and keeps saturating per-code counts.
module e2_out_decoder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [17:0]      y,
   input  logic             en,
   input  logic             clr,
   output logic [4:0]       ev_code,
   output logic             ev_valid,
   input  logic             ev_ready,
   input  logic [4:0]       sel,
   output logic [CNT_W-1:0] sel_count,
   output logic             illegal,
   output logic             ovf
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   logic [4:0]       code;
   logic [PW-1:0]    wr_q, rd_q;
   logic [4:0]       mem_q [DEPTH];
   logic [CNT_W-1:0] cnt_q [17];
   logic [CNT_W-1:0] sel_d;
   logic             empty, full, sample, push, pop;

   always_comb begin
      case (y)
         18'h00000: code = 5'd0;
         18'h00001: code = 5'd1;
         18'h00002: code = 5'd2;
         18'h00004: code = 5'd3;
         18'h00008: code = 5'd4;
         18'h00010: code = 5'd5;
         18'h00020: code = 5'd6;
         18'h20800: code = 5'd7;
         18'h04000: code = 5'd8;
         18'h01000: code = 5'd9;
         18'h08000: code = 5'd10;
         18'h00200: code = 5'd11;
         18'h00c01: code = 5'd12;
         18'h10080: code = 5'd13;
         18'h02000: code = 5'd14;
         18'h00d00: code = 5'd15;
         18'h000c0: code = 5'd16;
         default:   code = 5'd31;
      endcase
   end

   assign empty    = (wr_q == rd_q);
   assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign sample   = en && (code != 5'd0);
   assign pop      = !empty && ev_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push     = sample && (!full || pop);
   assign ev_valid = !empty;
   assign ev_code  = empty ? 5'd0 : mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         ovf     <= 1'b0;
         illegal <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr) begin
         wr_q    <= '0;
         rd_q    <= '0;
         ovf     <= 1'b0;
         illegal <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_q[AW-1:0]] <= code;
            wr_q                <= wr_q + PW'(1);
         end
         if (pop) rd_q <= rd_q + PW'(1);
         if (sample && full && !pop) ovf <= 1'b1;
         if (en && (code == 5'd31)) illegal <= 1'b1;
      end
   end

   // Slot 0 holds the illegal-pattern count; slots 1..16 map directly to codes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 17; i++) cnt_q[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < 17; i++) cnt_q[i] <= '0;
      end else if (sample) begin
         for (int i = 0; i < 17; i++) begin
            if ((code == ((i == 0) ? 5'd31 : 5'(i))) && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      sel_d = '0;
      if (sel == 5'd31) sel_d = cnt_q[0];
      for (int i = 1; i < 17; i++) begin
         if (sel == 5'(i)) sel_d = cnt_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_count <= '0;
      end else if (clr) begin
         sel_count <= '0;
      end else begin
         sel_count <= sel_d;
      end
   end

endmodule

// File: tb/tb_e2_out_decoder.sv
// Directed bench for e2_out_decoder: a queue/array model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_e2_out_decoder;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [17:0]      y;
   logic             en, clr, ev_ready;
   logic [4:0]       sel;
   logic [4:0]       ev_code;
   logic             ev_valid, illegal, ovf;
   logic [CNT_W-1:0] sel_count;

   int checks = 0;
   int errors = 0;

   // Legal patterns indexed by their transition code.
   logic [17:0] pats [1:16] = '{18'h00001, 18'h00002, 18'h00004, 18'h00008,
                                18'h00010, 18'h00020, 18'h20800, 18'h04000,
                                18'h01000, 18'h08000, 18'h00200, 18'h00c01,
                                18'h10080, 18'h02000, 18'h00d00, 18'h000c0};

   int mq[$];
   int cnt [32];
   int m_ill, m_ovf, exp_sel;

   e2_out_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .y        (y),
      .en       (en),
      .clr      (clr),
      .ev_code  (ev_code),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .sel      (sel),
      .sel_count(sel_count),
      .illegal  (illegal),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input logic [17:0] v);
      if (v == 18'h0) return 0;
      for (int k = 1; k <= 16; k++) if (v == pats[k]) return k;
      return 31;
   endfunction

   function automatic void model_reset();
      mq.delete();
      foreach (cnt[i]) cnt[i] = 0;
      m_ill = 0;
      m_ovf = 0;
      exp_sel = 0;
   endfunction

   function automatic void model_step();
      int c, pre, nsel;
      bit p;
      nsel = 0;
      if (sel >= 5'd1 && sel <= 5'd16) nsel = cnt[sel];
      else if (sel == 5'd31) nsel = cnt[31];
      if (clr) begin
         model_reset();
         return;
      end
      exp_sel = nsel;
      c   = decode(y);
      pre = mq.size();
      p   = (pre > 0) && ev_ready;
      if (p) void'(mq.pop_front());
      if (en && c != 0) begin
         if (pre < DEPTH || p) mq.push_back(c);
         else m_ovf = 1;
         if (cnt[c] < MAXC) cnt[c]++;
         if (c == 31) m_ill = 1;
      end
   endfunction

   task automatic check_all();
      chk("ev_valid", ev_valid, (mq.size() > 0) ? 1 : 0);
      chk("ev_code", ev_code, (mq.size() > 0) ? mq[0] : 0);
      chk("illegal", illegal, m_ill);
      chk("ovf", ovf, m_ovf);
      chk("sel_count", sel_count, exp_sel);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic push(input logic [17:0] v);
      en = 1'b1;
      y  = v;
      cycle();
   endtask

   int drain [4] = '{4, 7, 9, 5};

   initial begin
      model_reset();
      rst = 1'b1; y = '0; en = 1'b0; clr = 1'b0; ev_ready = 1'b0; sel = '0;
      #1;
      chk("rst_valid", ev_valid, 0);
      chk("rst_code", ev_code, 0);
      chk("rst_sel", sel_count, 0);
      @(negedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check_all();

      // Decode sweep: each code visible one cycle after its sample.
      ev_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         push(pats[k]);
         chk("sweep_code", ev_code, k);
      end
      en = 1'b0; y = '0;
      for (int k = 1; k <= 16; k++) begin
         sel = 5'(k);
         cycle();
         chk("sweep_count", sel_count, 1);
      end
      chk("sweep_illegal", illegal, 0);

      // Illegal pattern.
      sel = 5'd31;
      push(18'h00003);
      chk("illegal_code", ev_code, 31);
      chk("illegal_flag", illegal, 1);
      en = 1'b0; y = '0;
      cycle();
      chk("illegal_count", sel_count, 1);
      push(18'h0);
      push(18'h0);
      chk("idle_no_event", ev_valid, 0);
      chk("idle_no_count", sel_count, 1);

      // FIFO boundary.
      ev_ready = 1'b0;
      push(pats[3]); push(pats[4]); push(pats[7]); push(pats[9]); push(pats[2]);
      chk("full_ovf", ovf, 1);
      chk("full_head", ev_code, 3);
      ev_ready = 1'b1;
      push(pats[5]);
      chk("full_pushpop_head", ev_code, 4);
      chk("full_pushpop_ovf", ovf, 1);
      en = 1'b0; y = '0;
      for (int i = 0; i < 4; i++) begin
         chk("drain", ev_code, drain[i]);
         cycle();
      end
      chk("drained", ev_valid, 0);

      // Saturation.
      sel = 5'd9;
      for (int i = 0; i < 300; i++) push(pats[9]);
      en = 1'b0; y = '0;
      cycle();
      chk("sat_count", sel_count, 255);
      for (int i = 0; i < 5; i++) push(pats[9]);
      en = 1'b0; y = '0;
      cycle();
      chk("sat_hold", sel_count, 255);

      // Asynchronous reset with three events queued.
      ev_ready = 1'b0;
      push(pats[1]); push(pats[2]); push(pats[3]);
      en = 1'b0; y = '0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_valid", ev_valid, 0);
      chk("arst_illegal", illegal, 0);
      chk("arst_ovf", ovf, 0);
      chk("arst_sel", sel_count, 0);
      @(posedge clk);
      @(negedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check_all();
      cycle();
      chk("post_rst_sel9", sel_count, 0);

      // clr priority over a same-cycle sample.
      sel = 5'd4;
      push(pats[4]); push(18'h00003); push(pats[1]); push(pats[6]); push(pats[2]);
      chk("pre_clr_ovf", ovf, 1);
      chk("pre_clr_ill", illegal, 1);
      chk("pre_clr_sel4", sel_count, 1);
      y = pats[4]; clr = 1'b1;
      cycle();
      chk("clr_valid", ev_valid, 0);
      chk("clr_sel", sel_count, 0);
      chk("clr_illegal", illegal, 0);
      chk("clr_ovf", ovf, 0);
      clr = 1'b0; en = 1'b0; y = '0;
      cycle();
      chk("clr_sel4", sel_count, 0);
      ev_ready = 1'b1;
      push(pats[7]);
      chk("post_clr_code", ev_code, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
